// File: rtl/bnn_sched_pkg.sv
// Shared types and helpers for the binary conv layer scheduler.
//   sched_state_t   : scheduler FSM encoding
//   default_timeout : RUN-state cycle budget derived from the core's nominal pass length
package bnn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    RUN,
    STORE,
    DONE,
    ERR
  } sched_state_t;

  // One core pass takes out_size^2*(ic+1) cycles; the margin covers handshake slack.
  function automatic int unsigned default_timeout(input int unsigned ic,
                                                  input int unsigned out_size);
    return out_size * out_size * (ic + 1) + 16;
  endfunction

endpackage

// File: rtl/conv_layer_sched.sv
// Sequences one binary 3x3 conv layer by running a single conv core once per
// output channel: fetch the channel's weight word, run the core, store its map.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a layer run (accepted only in IDLE or ERR)
//   busy              high in every state except IDLE and ERR
//   done              one-cycle pulse once every output channel map is written
//   err               sticky core-timeout flag, cleared by an accepted start
//   wmem_rd/addr      weight read strobe and word index; rdata valid next cycle
//   wmem_rdata        IC*9-bit weight word
//   core_en           core enable (low holds the core in clear)
//   core_weights      registered weight word, frozen while core_en is high
//   core_done/img     core completion strobe and result map
//   out_wr/oc/img     one-cycle output-buffer write of a channel's result map
module conv_layer_sched
  import bnn_sched_pkg::*;
#(
  parameter int unsigned IC           = 8,
  parameter int unsigned OC           = 8,
  parameter int unsigned IMG_IN_SIZE  = 30,
  parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE - 2,
  parameter int unsigned OC_W         = $clog2(OC > 1 ? OC : 2),
  parameter int unsigned TIMEOUT      = default_timeout(IC, IMG_OUT_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic                                 wmem_rd,
  output logic [OC_W-1:0]                      wmem_addr,
  input  logic [IC*9-1:0]                      wmem_rdata,
  output logic                                 core_en,
  output logic [IC*9-1:0]                      core_weights,
  input  logic                                 core_done,
  input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] core_img,
  output logic                                 out_wr,
  output logic [OC_W-1:0]                      out_oc,
  output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] out_img
);

  localparam int unsigned RC_W = $clog2(TIMEOUT);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(TIMEOUT - 1);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OC - 1);

  sched_state_t    state;
  logic [OC_W-1:0] oc;
  logic [RC_W-1:0] run_cnt;

  assign wmem_addr = oc;

  // All outputs are registered and set on the transition into the state
  // that owns them, so each strobe lines up exactly with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      oc           <= '0;
      run_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      wmem_rd      <= 1'b0;
      core_en      <= 1'b0;
      core_weights <= '0;
      out_wr       <= 1'b0;
      out_oc       <= '0;
      out_img      <= '0;
    end else begin
      wmem_rd <= 1'b0;
      out_wr  <= 1'b0;
      done    <= 1'b0;
      core_en <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            err     <= 1'b0;
            oc      <= '0;
            busy    <= 1'b1;
            wmem_rd <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          core_weights <= wmem_rdata;
          run_cnt      <= '0;
          core_en      <= 1'b1;
          state        <= RUN;
        end
        RUN: begin
          // core_done takes priority over a timeout on the same cycle
          if (core_done) begin
            out_img <= core_img;
            out_oc  <= oc;
            out_wr  <= 1'b1;
            run_cnt <= '0;
            state   <= STORE;
          end else if (run_cnt == RC_LAST) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            run_cnt <= '0;
            state   <= ERR;
          end else begin
            run_cnt <= run_cnt + RC_W'(1);
            core_en <= 1'b1;
          end
        end
        STORE: begin
          if (oc == OC_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            oc      <= oc + OC_W'(1);
            wmem_rd <= 1'b1;
            state   <= FETCH;
          end
        end
        DONE: begin
          oc    <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
